// File: rtl/polyph_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : polyph_tx_ctrl_pkg
// Brief   : Shared state encoding and default sizing for the TX polyphase
//           timing controller.
// Revision: 1.0 - initial release
// ============================================================================
package polyph_tx_ctrl_pkg;

   localparam int c_OS_DEFAULT     = 4;
   localparam int c_NBAUD_DEFAULT  = 6;
   localparam int c_NB_CNT_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

endpackage : polyph_tx_ctrl_pkg
`default_nettype wire

// File: rtl/polyph_tx_ctrl_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : mod_counter
// Brief   : Modulo-MOD up counter with count enable, synchronous clear and a
//           terminal-count (wrap) flag.
// Revision: 1.0 - initial release
// ============================================================================
module mod_counter #(
   parameter int MOD   = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == c_LAST) ? '0 : r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;
   assign o_wrap  = (r_count == c_LAST);

endmodule : mod_counter
`default_nettype wire

// File: rtl/polyph_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : polyph_tx_ctrl
// Brief   : Timing controller for the polyphase TX shaping filter: coefficient
//           phase, per-baud shift/symbol-request strobe, fill tracking.
// Revision: 1.0 - initial release
// ============================================================================
module polyph_tx_ctrl
   import polyph_tx_ctrl_pkg::*;
#(
   parameter int OS     = c_OS_DEFAULT,
   parameter int NBAUD  = c_NBAUD_DEFAULT,
   parameter int NB_CNT = c_NB_CNT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_hold,
   output logic [$clog2(OS)-1:0]   o_phase,
   output logic                    o_ctrl,
   output logic                    o_sym_req,
   output logic                    o_os_valid,
   output logic                    o_busy,
   output logic [NB_CNT-1:0]       o_sym_cnt
);

   localparam int NB_PH   = $clog2(OS);
   localparam int NB_FILL = $clog2(NBAUD + 1);
   localparam logic [NB_FILL-1:0] c_FILL_FULL = NB_FILL'(NBAUD);
   localparam logic [NB_FILL-1:0] c_FILL_LAST = NB_FILL'(NBAUD - 1);

   state_t              r_state;
   logic [NB_FILL-1:0]  r_fill_cnt;
   logic                r_stop_pend;
   logic [NB_CNT-1:0]   r_sym_cnt;

   logic [NB_PH-1:0]    w_phase;
   logic                w_phase_last;
   logic                w_active;
   logic                w_step;
   logic                w_sym_end;
   logic                w_shift;
   logic                w_stop;

   assign w_active  = (r_state != ST_IDLE);
   assign w_step    = w_active && !i_hold;
   assign w_sym_end = w_step && w_phase_last;
   // A pending stop turns the last phase of the symbol into a non-shifting exit.
   assign w_shift   = w_sym_end && !r_stop_pend;
   assign w_stop    = w_sym_end && r_stop_pend;

   mod_counter #(
      .MOD   (OS),
      .WIDTH (NB_PH)
   ) u_phase_cnt (
      .clk     (clk),
      .i_reset (i_reset),
      .i_en    (w_step),
      .i_clr   (!w_active),
      .o_count (w_phase),
      .o_wrap  (w_phase_last)
   );

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_fill_cnt  <= '0;
         r_stop_pend <= 1'b0;
         r_sym_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_enable) begin
                  r_state     <= ST_FILL;
                  r_fill_cnt  <= '0;
                  r_stop_pend <= 1'b0;
               end
            end
            ST_FILL, ST_RUN: begin
               if (w_stop) begin
                  r_state     <= ST_IDLE;
                  r_fill_cnt  <= '0;
                  r_stop_pend <= 1'b0;
               end else begin
                  r_stop_pend <= !i_enable;
                  if (w_shift) begin
                     r_sym_cnt <= r_sym_cnt + NB_CNT'(1);
                     if (r_fill_cnt != c_FILL_FULL) begin
                        r_fill_cnt <= r_fill_cnt + NB_FILL'(1);
                     end
                     if (r_state == ST_FILL && r_fill_cnt == c_FILL_LAST) begin
                        r_state <= ST_RUN;
                     end
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_fill_cnt  <= '0;
               r_stop_pend <= 1'b0;
            end
         endcase
      end
   end

   assign o_phase    = w_phase;
   assign o_ctrl     = w_shift;
   assign o_sym_req  = w_shift;
   assign o_os_valid = (r_state == ST_RUN) && !i_hold;
   assign o_busy     = w_active;
   assign o_sym_cnt  = r_sym_cnt;

endmodule : polyph_tx_ctrl
`default_nettype wire

// File: tb/tb_polyph_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_polyph_tx_ctrl
// Brief   : Self-checking bench for polyph_tx_ctrl (OS=4, NBAUD=6, NB_CNT=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_polyph_tx_ctrl;

   localparam int OS     = 4;
   localparam int NBAUD  = 6;
   localparam int NB_CNT = 16;

   logic              clk      = 1'b0;
   logic              i_reset  = 1'b1;
   logic              i_enable = 1'b0;
   logic              i_hold   = 1'b0;
   logic [1:0]        o_phase;
   logic              o_ctrl;
   logic              o_sym_req;
   logic              o_os_valid;
   logic              o_busy;
   logic [NB_CNT-1:0] o_sym_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   polyph_tx_ctrl #(
      .OS     (OS),
      .NBAUD  (NBAUD),
      .NB_CNT (NB_CNT)
   ) dut (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_hold     (i_hold),
      .o_phase    (o_phase),
      .o_ctrl     (o_ctrl),
      .o_sym_req  (o_sym_req),
      .o_os_valid (o_os_valid),
      .o_busy     (o_busy),
      .o_sym_cnt  (o_sym_cnt)
   );

   // Reference model: active flag, phase, symbols shifted since start, stop request.
   logic              m_active  = 1'b0;
   int                m_phase   = 0;
   int                m_filled  = 0;
   logic              m_stop    = 1'b0;
   logic [NB_CNT-1:0] m_cnt     = '0;
   int                preload_seq = 0;
   int                m_seen      = 0;
   logic              chk_en      = 1'b0;

   always @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         m_active <= 1'b0;
         m_phase  <= 0;
         m_filled <= 0;
         m_stop   <= 1'b0;
         m_cnt    <= '0;
      end else begin
         if (!m_active) begin
            if (i_enable) begin
               m_active <= 1'b1;
               m_phase  <= 0;
               m_filled <= 0;
               m_stop   <= 1'b0;
            end
         end else if (i_hold) begin
            m_stop <= !i_enable;
         end else if (m_phase == OS - 1 && m_stop) begin
            m_active <= 1'b0;
            m_phase  <= 0;
            m_filled <= 0;
            m_stop   <= 1'b0;
         end else begin
            m_stop  <= !i_enable;
            m_phase <= (m_phase + 1) % OS;
            if (m_phase == OS - 1) begin
               m_cnt <= m_cnt + 16'd1;
               if (m_filled < NBAUD) m_filled <= m_filled + 1;
            end
         end
         if (preload_seq != m_seen) begin
            m_seen <= preload_seq;
            m_cnt  <= 16'hFFFF;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_phase",   32'(o_phase),    32'(m_phase));
         check("cmp_busy",    32'(o_busy),     32'(m_active));
         check("cmp_ctrl",    32'(o_ctrl),
               32'(m_active && m_phase == OS - 1 && !i_hold && !m_stop));
         check("cmp_sym_req", 32'(o_sym_req),
               32'(m_active && m_phase == OS - 1 && !i_hold && !m_stop));
         check("cmp_valid",   32'(o_os_valid), 32'(m_active && m_filled >= NBAUD && !i_hold));
         check("cmp_cnt",     32'(o_sym_cnt),  32'(m_cnt));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic go_phase(input int p);
      int g;
      g = 0;
      do begin
         cyc();
         g++;
      end while (32'(o_phase) != p && g < 16);
      check("nav_phase", 32'(o_phase), 32'(p));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      i_reset = 1'b0;
      chk_en  = 1'b1;
      @(negedge clk);
      check("rst_phase", 32'(o_phase),    32'd0);
      check("rst_busy",  32'(o_busy),     32'd0);
      check("rst_ctrl",  32'(o_ctrl),     32'd0);
      check("rst_valid", 32'(o_os_valid), 32'd0);
      check("rst_cnt",   32'(o_sym_cnt),  32'd0);

      // Start: enable seen at edge 0, cycles numbered from there.
      cyc();
      i_enable = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         cyc();
         @(negedge clk);
         check("t1_phase", 32'(o_phase),    32'((c - 1) % 4));
         check("t1_ctrl",  32'(o_ctrl),     32'(c % 4 == 0));
         check("t1_valid", 32'(o_os_valid), 32'(c >= 25));
      end

      // Stop requested at phase 1: the pending symbol is dropped.
      go_phase(1);
      i_enable = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      check("t2_phase3", 32'(o_phase), 32'd3);
      check("t2_noctrl", 32'(o_ctrl),  32'd0);
      cyc();
      @(negedge clk);
      check("t2_idle",  32'(o_busy),    32'd0);
      check("t2_phase", 32'(o_phase),   32'd0);
      check("t2_cnt",   32'(o_sym_cnt), 32'd7);

      // Restart, refill, then a cancelled stop.
      i_enable = 1'b1;
      repeat (NBAUD * OS + 2) cyc();
      @(negedge clk);
      check("t3_valid_run", 32'(o_os_valid), 32'd1);
      go_phase(1);
      i_enable = 1'b0;
      cyc();
      i_enable = 1'b1;
      cyc();
      @(negedge clk);
      check("t3_phase3", 32'(o_phase), 32'd3);
      check("t3_ctrl",   32'(o_ctrl),  32'd1);
      cyc();
      @(negedge clk);
      check("t3_busy",  32'(o_busy),     32'd1);
      check("t3_valid", 32'(o_os_valid), 32'd1);
      check("t3_phase", 32'(o_phase),    32'd0);

      // Hold for three cycles on phase 3.
      go_phase(3);
      i_hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         check("t4_hold_phase", 32'(o_phase),    32'd3);
         check("t4_hold_ctrl",  32'(o_ctrl),     32'd0);
         check("t4_hold_valid", 32'(o_os_valid), 32'd0);
         cyc();
      end
      i_hold = 1'b0;
      @(negedge clk);
      check("t4_rel_phase", 32'(o_phase),    32'd3);
      check("t4_rel_ctrl",  32'(o_ctrl),     32'd1);
      check("t4_rel_valid", 32'(o_os_valid), 32'd1);
      cyc();
      @(negedge clk);
      check("t4_after_phase", 32'(o_phase), 32'd0);
      check("t4_after_ctrl",  32'(o_ctrl),  32'd0);

      // Asynchronous reset in the middle of a fill.
      i_enable = 1'b0;
      for (int k = 0; k < 16 && o_busy; k++) cyc();
      check("t5_stopped", 32'(o_busy), 32'd0);
      i_enable = 1'b1;
      cyc();
      go_phase(2);
      check("t5_fill_busy", 32'(o_busy), 32'd1);
      #2;
      i_reset = 1'b1;
      #1;
      check("t5_phase",   32'(o_phase),    32'd0);
      check("t5_ctrl",    32'(o_ctrl),     32'd0);
      check("t5_symreq",  32'(o_sym_req),  32'd0);
      check("t5_valid",   32'(o_os_valid), 32'd0);
      check("t5_busy",    32'(o_busy),     32'd0);
      check("t5_cnt",     32'(o_sym_cnt),  32'd0);
      cyc();
      i_reset = 1'b0;

      // Counter wrap via preload.
      cyc();
      go_phase(2);
      @(negedge clk);
      #1;
      force dut.r_sym_cnt = 16'hFFFF;
      preload_seq++;
      #1;
      release dut.r_sym_cnt;
      cyc();
      @(negedge clk);
      check("t6_phase3", 32'(o_phase),   32'd3);
      check("t6_pre",    32'(o_sym_cnt), 32'h0000_FFFF);
      check("t6_ctrl",   32'(o_ctrl),    32'd1);
      cyc();
      @(negedge clk);
      check("t6_wrap",   32'(o_sym_cnt), 32'd0);
      check("t6_phase0", 32'(o_phase),   32'd0);
      cyc();
      @(negedge clk);
      check("t6_phase1", 32'(o_phase),   32'd1);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_polyph_tx_ctrl
`default_nettype wire
